check_scan_ctrl: RTL



---
 rtl/check_scan_pkg.sv | 21 ++
 rtl/check_snapshot_buf.sv | 31 +++
 rtl/check_scan_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/check_scan_pkg.sv
// Shared definitions for the check-data sweep controller: FSM encoding,
// default tap count and the named debug tap indices of the CPU check mux.
package check_scan_pkg;

    localparam int NUM_TAPS_DEFAULT = 29;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

    // Well-known taps of the CPU debug mux
    localparam int TAP_PC_CUR  = 0;
    localparam int TAP_INSTR   = 1;
    localparam int TAP_RF_WD   = 12;
    localparam int TAP_ALU_ANS = 18;
    localparam int TAP_PC_NEXT = 24;
    localparam int TAP_DM_WE   = 28;

endpackage

// File: rtl/check_snapshot_buf.sv
// Snapshot register file: one write port filled during the sweep, one
// asynchronous read port feeding the output stream. Contents are never
// cleared; every sweep overwrites all entries before they are streamed.
module check_snapshot_buf
    import check_scan_pkg::*;
#(
    parameter int NUM_TAPS = NUM_TAPS_DEFAULT,
    parameter int DW       = 32,
    parameter int AW       = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [NUM_TAPS];

    // Capture one tap word per cycle while the sweep is running
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read so out_data follows out_idx without a cycle of lag
    assign rdata = mem[raddr];

endmodule

// File: rtl/check_scan_ctrl.sv
// Debug-sweep controller: on trigger, stalls the CPU, steps check_addr over
// every tap capturing each word, then releases the CPU and streams the
// frozen snapshot out over a valid/ready handshake.
module check_scan_ctrl
    import check_scan_pkg::*;
#(
    parameter int NUM_TAPS = NUM_TAPS_DEFAULT,
    parameter int DW       = 32,
    parameter int AW       = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trigger,
    output logic [AW-1:0] check_addr,
    input  logic [DW-1:0] check_data,
    output logic          cpu_stall,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_last
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_TAPS - 1);

    scan_state_t   state_reg, state_next;
    logic [AW-1:0] scan_cnt_reg, scan_cnt_next;
    logic [AW-1:0] out_idx_reg, out_idx_next;
    logic          buf_we;

    // State and counter registers; reset aborts any sweep or drain at once
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            scan_cnt_reg <= '0;
            out_idx_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            scan_cnt_reg <= scan_cnt_next;
            out_idx_reg  <= out_idx_next;
        end
    end

    // Next-state logic; scan counter is held at 0 outside SCAN so it can
    // drive check_addr directly
    always_comb begin
        state_next    = state_reg;
        scan_cnt_next = scan_cnt_reg;
        out_idx_next  = out_idx_reg;
        buf_we        = 1'b0;
        unique case (state_reg)
            IDLE: begin
                scan_cnt_next = '0;
                out_idx_next  = '0;
                if (trigger) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                buf_we = 1'b1;
                if (scan_cnt_reg == LAST_IDX) begin
                    scan_cnt_next = '0;
                    state_next    = DRAIN;
                end else begin
                    scan_cnt_next = scan_cnt_reg + 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (out_idx_reg == LAST_IDX) begin
                        out_idx_next = '0;
                        state_next   = IDLE;
                    end else begin
                        out_idx_next = out_idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    check_snapshot_buf #(
        .NUM_TAPS (NUM_TAPS),
        .DW       (DW),
        .AW       (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (scan_cnt_reg),
        .wdata (check_data),
        .raddr (out_idx_reg),
        .rdata (out_data)
    );

    assign check_addr = scan_cnt_reg;
    assign cpu_stall  = (state_reg == SCAN);
    assign busy       = (state_reg != IDLE);
    assign out_valid  = (state_reg == DRAIN);
    assign out_idx    = out_idx_reg;
    assign out_last   = out_valid && (out_idx_reg == LAST_IDX);

endmodule
